// File: rtl/dem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dem_pkg
// Purpose  : Shared types and constants for the DEM switching tree.
//            - Fibonacci LFSR tap masks per supported width (8/16/32)
//            - Per-node split selection encoding
//            - Node index helper (level k, position j) -> flat node number
// Revision : 1.0 - initial release
// ============================================================================
package dem_pkg;

  // Tap masks: feedback bit = XOR of all state bits selected by the mask,
  // shifted into bit 0 while the register shifts towards the MSB.
  //   8 : x^8  + x^6  + x^5 + x^4 + 1
  //   16: x^16 + x^14 + x^13 + x^11 + 1
  //   32: x^32 + x^22 + x^2 + x^1 + 1
  localparam logic [31:0] c_lfsr_taps_w8  = 32'h0000_00B8;
  localparam logic [31:0] c_lfsr_taps_w16 = 32'h0000_B400;
  localparam logic [31:0] c_lfsr_taps_w32 = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_ZERO = 2'd0,
    S_POS  = 2'd1,
    S_NEG  = 2'd2
  } dem_sel_e;

  function automatic logic [31:0] dem_lfsr_taps(input int unsigned w);
    case (w)
      8:       return c_lfsr_taps_w8;
      32:      return c_lfsr_taps_w32;
      default: return c_lfsr_taps_w16;
    endcase
  endfunction

  // Breadth-first node numbering: root is 0, level k starts at 2**k - 1.
  function automatic int unsigned dem_node_idx(input int unsigned k, input int unsigned j);
    return (32'd1 << k) - 32'd1 + j;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dem_switch_node.sv
`default_nettype none
// ============================================================================
// Module   : dem_switch_node
// Purpose  : One two-way DEM switching node. Splits value x into
//            x1 = (x+s)/2 and x2 = (x-s)/2 with s in {-1,0,+1}.
//            Odd x: steer 0 -> s=+1, steer 1 -> s=-1. Even x: s=0.
// Config   : DEM_SHAPING_EN - adds a 1-bit state p per node; for odd x the
//            effective steer is p ^ steer_i and p toggles on valid samples.
// Ports    : clk_i/reset_i (shaping build only), valid_i, x_i[XW],
//            steer_i, x1_o/x2_o[XW-1], sel_o
// Revision : 1.0 - initial release
// ============================================================================
module dem_switch_node
  import dem_pkg::*;
#(
  parameter int unsigned XW = 2
) (
`ifdef DEM_SHAPING_EN
  input  logic          clk_i,
  input  logic          reset_i,
`endif
  input  logic          valid_i,
  input  logic [XW-1:0] x_i,
  input  logic          steer_i,
  output logic [XW-2:0] x1_o,
  output logic [XW-2:0] x2_o,
  output dem_sel_e      sel_o
);

  localparam logic [XW-2:0] C_ONE = (XW-1)'(1);

  logic [XW-2:0] half_w;
  logic          steer_w;

  assign half_w = x_i[XW-1:1];

`ifdef DEM_SHAPING_EN
  logic p_q;

  // Toggling p on every odd valid sample alternates the sign of the
  // leftover unit, which first-order shapes the element mismatch.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      p_q <= 1'b0;
    end else if (valid_i && x_i[0]) begin
      p_q <= ~p_q;
    end
  end

  assign steer_w = p_q ^ steer_i;
`else
  logic unused_valid_w;
  assign unused_valid_w = valid_i;
  assign steer_w        = steer_i;
`endif

  // For odd x the extra unit goes to x1 (s=+1) or x2 (s=-1); the larger
  // half never exceeds 2**(XW-2) because odd x is at most 2**(XW-1)-1.
  always_comb begin
    sel_o = S_ZERO;
    x1_o  = half_w;
    x2_o  = half_w;
    if (x_i[0]) begin
      if (steer_w) begin
        sel_o = S_NEG;
        x2_o  = half_w + C_ONE;
      end else begin
        sel_o = S_POS;
        x1_o  = half_w + C_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dem_switch_tree.sv
`default_nettype none
// ============================================================================
// Module   : dem_switch_tree
// Purpose  : Pipelined tree DEM encoder. A binary code is clamped to
//            2**LEVELS, then split through LEVELS registered levels of
//            switching nodes into 2**LEVELS unit-element bits. Odd splits
//            are steered by a free-running Fibonacci LFSR (gated by pn_en_i).
// Config   : DEM_SHAPING_EN - per-node first-order shaping state.
// Ports    : clk_i, reset_i (async, active-high), valid_i, code_i[LEVELS+1],
//            pn_en_i, valid_o, elem_o[2**LEVELS], ovf_o
// Latency  : LEVELS cycles, one sample per cycle, no backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module dem_switch_tree
  import dem_pkg::*;
#(
  parameter int unsigned LEVELS    = 3,
  parameter int unsigned LFSR_W    = 16,
  parameter logic [31:0] LFSR_SEED = 32'h0000_ACE1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 valid_i,
  input  logic [LEVELS:0]      code_i,
  input  logic                 pn_en_i,
  output logic                 valid_o,
  output logic [2**LEVELS-1:0] elem_o,
  output logic                 ovf_o
);

  localparam int unsigned       c_n_elem   = 2**LEVELS;
  localparam logic [LEVELS:0]   c_full     = c_n_elem[LEVELS:0];
  localparam logic [31:0]       c_taps_all = dem_lfsr_taps(LFSR_W);
  localparam logic [LFSR_W-1:0] c_taps     = c_taps_all[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] c_seed     = LFSR_SEED[LFSR_W-1:0];

  // ---------------------------------------------------------------- clamp
  logic            ovf_w;
  logic [LEVELS:0] code_cl_w;

  assign ovf_w     = (code_i > c_full);
  assign code_cl_w = ovf_w ? c_full : code_i;

  // ----------------------------------------------------------------- LFSR
  // Free-running: advances every cycle so the PN pattern is independent of
  // the input valid pattern.
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  assign lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & c_taps)};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr_q <= c_seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // ----------------------------------------------------------- tree levels
  // Level k combines its 2**k nodes with the register stage k+1 that
  // captures their children. Stage data is a flat vector, child 2j/2j+1
  // of node j occupying consecutive (XW-1)-bit slots.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned c_xw = LEVELS - k + 1;
    localparam int unsigned c_nn = 2**k;

    logic [c_nn*c_xw-1:0]       x_w;
    logic                       vld_in_w;
    logic                       ovf_in_w;
    logic [2*c_nn*(c_xw-1)-1:0] stg_d;
    logic [2*c_nn*(c_xw-1)-1:0] stg_q;
    logic                       vld_q;
    logic                       ovf_q;

    if (k == 0) begin : g_src
      assign x_w      = code_cl_w;
      assign vld_in_w = valid_i;
      assign ovf_in_w = ovf_w;
    end else begin : g_src
      assign x_w      = g_lvl[k-1].stg_q;
      assign vld_in_w = g_lvl[k-1].vld_q;
      assign ovf_in_w = g_lvl[k-1].ovf_q;
    end

    for (genvar j = 0; j < c_nn; j++) begin : g_node
      localparam int unsigned c_idx = dem_node_idx(k, j);
      localparam int unsigned c_bit = c_idx % LFSR_W;

      dem_sel_e unused_sel_w;

      dem_switch_node #(
        .XW (c_xw)
      ) u_node (
`ifdef DEM_SHAPING_EN
        .clk_i   (clk_i),
        .reset_i (reset_i),
`endif
        .valid_i (vld_in_w),
        .x_i     (x_w[j*c_xw +: c_xw]),
        .steer_i (lfsr_q[c_bit] & pn_en_i),
        .x1_o    (stg_d[(2*j)*(c_xw-1) +: (c_xw-1)]),
        .x2_o    (stg_d[(2*j+1)*(c_xw-1) +: (c_xw-1)]),
        .sel_o   (unused_sel_w)
      );
    end

    // Valid shifts every cycle; data and ovf load only behind a valid so
    // bubbles leave the previous sample visible downstream.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        stg_q <= '0;
        vld_q <= 1'b0;
        ovf_q <= 1'b0;
      end else begin
        vld_q <= vld_in_w;
        if (vld_in_w) begin
          stg_q <= stg_d;
          ovf_q <= ovf_in_w;
        end
      end
    end
  end

  // Last stage holds 2**LEVELS one-bit leaves, LSB-first.
  assign valid_o = g_lvl[LEVELS-1].vld_q;
  assign elem_o  = g_lvl[LEVELS-1].stg_q;
  assign ovf_o   = g_lvl[LEVELS-1].ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dem_switch_tree.sv
`default_nettype none
// ============================================================================
// Module   : tb_dem_switch_tree
// Purpose  : Self-checking bench for dem_switch_tree (LEVELS=3, LFSR_W=16)
//            plus a LEVELS=1 instance for the shaping behaviour.
//            Expected outputs come from a behavioural tree/LFSR model and are
//            queued at drive time, then popped when valid_o appears.
// Config   : DEM_SHAPING_EN - model tracks per-node shaping state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dem_switch_tree;

  localparam int          LEVELS = 3;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int          NTAB   = 24;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       valid_i;
  logic [3:0] code_i;
  logic       pn_en_i;
  logic       valid_o;
  logic [7:0] elem_o;
  logic       ovf_o;

  logic       valid1_i;
  logic [1:0] code1_i;
  logic       pn1_i;
  logic       valid1_o;
  logic [1:0] elem1_o;
  logic       ovf1_o;

  always #5 clk_i = ~clk_i;

  dem_switch_tree #(
    .LEVELS    (3),
    .LFSR_W    (16),
    .LFSR_SEED (32'h0000_ACE1)
  ) u_dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .code_i  (code_i),
    .pn_en_i (pn_en_i),
    .valid_o (valid_o),
    .elem_o  (elem_o),
    .ovf_o   (ovf_o)
  );

  dem_switch_tree #(
    .LEVELS    (1),
    .LFSR_W    (16),
    .LFSR_SEED (32'h0000_ACE1)
  ) u_dut1 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (valid1_i),
    .code_i  (code1_i),
    .pn_en_i (pn1_i),
    .valid_o (valid1_o),
    .elem_o  (elem1_o),
    .ovf_o   (ovf1_o)
  );

  typedef struct {
    int         due;
    logic [7:0] elem;
    logic       ovf;
    int         code;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc      = 0;
  logic [15:0] m_lfsr;
  logic       m_p [7];
  logic [7:0] hold_exp;
  logic       tv [NTAB];
  int         tc [NTAB];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference split: level k evaluates k cycles after the root, so it sees
  // the LFSR stepped k times from the value present when the sample enters.
  task automatic predict(input int code, input logic pn, output logic [7:0] elem,
                         output logic ovf, output int ccl);
    int          vals [8];
    int          nxt  [8];
    logic [15:0] l;
    ovf  = (code > 8);
    ccl  = ovf ? 8 : code;
    vals = '{default: 0};
    vals[0] = ccl;
    l = m_lfsr;
    for (int k = 0; k < LEVELS; k++) begin
      nxt = '{default: 0};
      for (int j = 0; j < (1 << k); j++) begin
        int   n;
        int   x;
        int   s;
        logic st;
        n  = (1 << k) - 1 + j;
        x  = vals[j];
        st = l[n % 16] & pn;
`ifdef DEM_SHAPING_EN
        if (x % 2 == 1) begin
          st     = st ^ m_p[n];
          m_p[n] = ~m_p[n];
        end
`endif
        s = (x % 2 == 0) ? 0 : (st ? -1 : 1);
        nxt[2*j]   = (x + s) / 2;
        nxt[2*j+1] = (x - s) / 2;
      end
      vals = nxt;
      l    = lfsr_step(l);
    end
    for (int j = 0; j < 8; j++) elem[j] = (vals[j] == 1);
  endtask

  // One clock: update LFSR model, then sample outputs 1 time unit later.
  task automatic tick();
    exp_t e;
    @(posedge clk_i);
    if (reset_i) m_lfsr = SEED;
    else         m_lfsr = lfsr_step(m_lfsr);
    cyc++;
    #1;
    if (valid_o) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", 64'(valid_o), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("latency", 64'(cyc), 64'(e.due));
        check("elem", 64'(elem_o), 64'(e.elem));
        check("ovf", 64'(ovf_o), 64'(e.ovf));
        check("popcount", 64'($countones(elem_o)), 64'(e.code));
        hold_exp = e.elem;
      end
    end else begin
      check("hold", 64'(elem_o), 64'(hold_exp));
      if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        check("missing_valid", 64'(valid_o), 64'd1);
        void'(sb_q.pop_front());
      end
    end
  endtask

  task automatic drive(input logic v, input int code);
    logic [7:0] e;
    logic       o;
    int         c;
    valid_i = v;
    code_i  = 4'(code);
    if (v) begin
      predict(code, pn_en_i, e, o, c);
      sb_q.push_back('{cyc + LEVELS, e, o, c});
    end
    tick();
  endtask

  // Directed sample with a hand-derived pattern for the plain build.
  task automatic drive_k(input int code, input logic [7:0] k_elem);
    logic [7:0] e;
    logic       o;
    int         c;
    valid_i = 1'b1;
    code_i  = 4'(code);
    predict(code, pn_en_i, e, o, c);
`ifndef DEM_SHAPING_EN
    e = k_elem;
`endif
    sb_q.push_back('{cyc + LEVELS, e, o, c});
    tick();
  endtask

  task automatic flush(input int n);
    repeat (n) drive(1'b0, 0);
  endtask

  task automatic do_reset();
    #1;
    reset_i = 1'b1;
    #1;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_elem", 64'(elem_o), 64'd0);
    check("rst_ovf", 64'(ovf_o), 64'd0);
    sb_q.delete();
    m_lfsr   = SEED;
    m_p      = '{default: 1'b0};
    hold_exp = '0;
    valid_i  = 1'b0;
    tick();
    reset_i = 1'b0;
  endtask

  task automatic run_table();
    for (int i = 0; i < NTAB; i++) drive(tv[i], tc[i]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i  = 1'b1;
    valid_i  = 1'b0;
    code_i   = '0;
    pn_en_i  = 1'b0;
    valid1_i = 1'b0;
    code1_i  = '0;
    pn1_i    = 1'b0;
    m_lfsr   = SEED;
    m_p      = '{default: 1'b0};
    hold_exp = '0;
    for (int i = 0; i < NTAB; i++) begin
      tv[i] = ($urandom_range(0, 2) != 0);
      tc[i] = $urandom_range(0, 15);
    end

    repeat (2) tick();
    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_elem", 64'(elem_o), 64'd0);
    check("reset_ovf", 64'(ovf_o), 64'd0);
    reset_i = 1'b0;

    // Deterministic splits, clamp and ovf tracking.
    pn_en_i = 1'b0;
    drive_k(5, 8'h57);
    drive_k(8, 8'hFF);
    drive_k(0, 8'h00);
    drive_k(9, 8'hFF);
    drive_k(3, 8'h15);
    flush(5);

    // Bubbles: valid 1,0,0,1.
    drive_k(6, 8'h77);
    drive(1'b0, 0);
    drive(1'b0, 0);
    drive_k(2, 8'h11);
    flush(5);

    // Single-level tree: odd code twice in deterministic mode.
    valid1_i = 1'b1;
    code1_i  = 2'd1;
    tick();
    check("lvl1_valid_a", 64'(valid1_o), 64'd1);
    check("lvl1_elem_a", 64'(elem1_o), 64'd1);
    tick();
    check("lvl1_valid_b", 64'(valid1_o), 64'd1);
`ifdef DEM_SHAPING_EN
    check("lvl1_elem_b", 64'(elem1_o), 64'd2);
`else
    check("lvl1_elem_b", 64'(elem1_o), 64'd1);
`endif
    valid1_i = 1'b0;
    tick();
    check("lvl1_bubble", 64'(valid1_o), 64'd0);

    // PN run from the seed, then reset mid-stream and repeat it.
    pn_en_i = 1'b1;
    do_reset();
    run_table();
    flush(4);
    drive(1'b1, 4);
    drive(1'b1, 7);
    do_reset();
    run_table();
    flush(4);

    // Randomised invariant with valid gaps.
    for (int i = 0; i < 10000; i++) begin
      drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 8)));
    end
    flush(5);
    check("drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
